sysid_checker: RTL

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its 32-bit readdata. After reset (or on request), it reads the ID word at address 0 and the timestamp word at address 1, then compares both against build-time expected values. It raises sticky pass/fail status for boot logic and the reset/LED controller. A mismatched pair is retried a bounded number of times before fail is declared.

---
 rtl/sysid_pkg.sv | 22 ++
 rtl/sysid_lat_counter.sv | 29 ++
 rtl/sysid_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID checker: state encoding, slave word
// addresses and counter widths.
package sysid_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ID   = 3'd1;
    localparam logic [2:0] ST_WAIT_ID = 3'd2;
    localparam logic [2:0] ST_RD_TS   = 3'd3;
    localparam logic [2:0] ST_WAIT_TS = 3'd4;
    localparam logic [2:0] ST_COMPARE = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // Word addresses inside the system-ID slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Width of the attempts counter and of the read-latency counter
    localparam int ATTEMPTS_W = 4;
    localparam int LAT_W      = 3;

endpackage

// File: rtl/sysid_lat_counter.sv
// Loadable down-counter used to time the read-data capture in the WAIT
// states. Loaded while a read strobe is out, it counts down to zero and
// holds there; zero marks the capture cycle.
module sysid_lat_counter
    import sysid_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_value,
    output logic             zero
);

    logic [LAT_W-1:0] count;

    // Load on request, otherwise count down and stick at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that reads the system-ID slave (ID at address 0,
// timestamp at address 1), compares both words with build-time values,
// retries a bounded number of times and reports sticky pass/fail.
//
// Read handshake: the slave has no waitrequest. avm_read is high for exactly
// one cycle per access with avm_address valid in that cycle; avm_readdata is
// sampled READ_LATENCY cycles later (same edge when READ_LATENCY is 0).
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
    parameter int          READ_LATENCY       = 0,
    parameter int          MAX_RETRIES        = 3,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  avm_address,
    output logic                  avm_read,
    input  logic [31:0]           avm_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [31:0]           id_value,
    output logic [31:0]           ts_value,
    output logic [ATTEMPTS_W-1:0] attempts,
    output logic [2:0]            dbg_state
);

    localparam int               LAT_LOAD_I  = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic [LAT_W-1:0] LAT_LOAD    = LAT_W'(LAT_LOAD_I);
    localparam logic [ATTEMPTS_W-1:0] RETRY_LIMIT = ATTEMPTS_W'(MAX_RETRIES);
    localparam logic [ATTEMPTS_W-1:0] ATT_MAX     = {ATTEMPTS_W{1'b1}};

    logic [2:0] state;
    logic       auto_pending;
    logic       lat_zero;
    logic       launch;
    logic       words_match;
    logic       may_retry;

    // One counter serves both reads; it is reloaded in each read-strobe cycle
    sysid_lat_counter u_lat (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (avm_read),
        .load_value (LAT_LOAD),
        .zero       (lat_zero)
    );

    assign avm_read    = (state == ST_RD_ID) || (state == ST_RD_TS);
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign dbg_state   = state;
    assign launch      = (start || auto_pending) && !busy;
    assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
    // attempts cannot exceed its 4-bit range, so with MAX_RETRIES=15 the
    // check stops after 15 pairs instead of wrapping to zero
    assign may_retry   = (attempts <= RETRY_LIMIT) && (attempts != ATT_MAX);

    // Main FSM with capture, attempt and status registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            auto_pending <= AUTO_START;
            avm_address  <= SYSID_ADDR_ID;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
            attempts     <= '0;
        end else begin
            done         <= 1'b0;
            auto_pending <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        state       <= ST_RD_ID;
                        avm_address <= SYSID_ADDR_ID;
                        attempts    <= ATTEMPTS_W'(1);
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (READ_LATENCY == 0) begin
                        id_value    <= avm_readdata;
                        state       <= ST_RD_TS;
                        avm_address <= SYSID_ADDR_TS;
                    end else begin
                        state <= ST_WAIT_ID;
                    end
                end
                ST_WAIT_ID: begin
                    if (lat_zero) begin
                        id_value    <= avm_readdata;
                        state       <= ST_RD_TS;
                        avm_address <= SYSID_ADDR_TS;
                    end
                end
                ST_RD_TS: begin
                    if (READ_LATENCY == 0) begin
                        ts_value <= avm_readdata;
                        state    <= ST_COMPARE;
                    end else begin
                        state <= ST_WAIT_TS;
                    end
                end
                ST_WAIT_TS: begin
                    if (lat_zero) begin
                        ts_value <= avm_readdata;
                        state    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (words_match) begin
                        pass  <= 1'b1;
                        fail  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (may_retry) begin
                        attempts    <= attempts + 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        state       <= ST_RD_ID;
                    end else begin
                        pass  <= 1'b0;
                        fail  <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
